// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin arbiter sharing one 1-bit 8:1 mux channel among 8 requesters.
//   Produces the mux select and a one-hot grant. A grant lasts until the owner
//   releases, the owner drops its request, or the hold limit is reached. Every
//   grant is followed by at least one idle cycle before the next one.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous reset, active-high
//   en       in   1  arbitration enable; low blocks new grants only
//   req      in   8  level requests, bit i = source i
//   rel      in   1  owner release (named rel because "release" is a reserved
//                    keyword); only looked at while a grant is active
//   sel      out  3  mux select = index of granted source, held while idle
//   grant    out  8  one-hot grant, zero when idle
//   busy     out  1  high while a grant is active
//   timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit
module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);

  logic [0:0]       state_reg;
  logic [2:0]       ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       sel_reg;
  logic [7:0]       grant_reg;
  logic             busy_reg;
  logic             timeout_reg;

  // Requests rotated so that bit 0 is the source currently holding top
  // priority (the one just after the last served source).
  logic [7:0] rot_req;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg + 3'(gi)];
    end
  endgenerate

  // Lowest rotated offset with a pending request wins.
  logic [2:0] win_off;
  logic [2:0] win_idx;

  always_comb begin
    win_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_off = 3'(k);
      end
    end
  end

  assign win_idx = ptr_reg + win_off;

  // Exit conditions while granted, in priority order: release, owner
  // withdrawal, hold limit. Timeout only flags the hold-limit-only case.
  logic owner_drop;
  logic hold_done;
  logic exit_now;
  logic forced_exit;

  assign owner_drop  = ~req[sel_reg];
  assign hold_done   = (cnt_reg == CNT_LAST);
  assign exit_now    = rel | owner_drop | hold_done;
  assign forced_exit = ~rel & ~owner_drop & hold_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= 3'd0;
      cnt_reg     <= '0;
      sel_reg     <= 3'd0;
      grant_reg   <= 8'd0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (en && (|req)) begin
          state_reg <= GRANT;
          sel_reg   <= win_idx;
          grant_reg <= 8'(1) << win_idx;
          busy_reg  <= 1'b1;
          cnt_reg   <= '0;
        end
      end else begin
        if (exit_now) begin
          state_reg   <= IDLE;
          grant_reg   <= 8'd0;
          busy_reg    <= 1'b0;
          cnt_reg     <= '0;
          ptr_reg     <= sel_reg + 3'd1;  // served source drops to lowest priority
          timeout_reg <= forced_exit;
        end else if (cnt_reg != CNT_SAT) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign sel     = sel_reg;
  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule
